// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl: start/done sequencer for the bounded i/sn counting loop
module loop_seq_ctrl #(
    parameter int W       = 8,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] n_in,
    input  logic         step_en,
    input  logic         abort,
    output logic         busy,
    output logic [W-1:0] i,
    output logic [W-1:0] sn,
    output logic         done,
    output logic         timeout,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [W-1:0]  n_reg, n_nxt, i_nxt, sn_nxt;
    logic [TO_W-1:0] wdog, wdog_nxt;
    logic          done_nxt, timeout_nxt, err_nxt;

    assign start_ready = state == IDLE;
    assign busy        = state == RUN;

    // register state, loop datapath, pulses and the sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            n_reg   <= '0;
            i       <= '0;
            sn      <= '0;
            wdog    <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            n_reg   <= n_nxt;
            i       <= i_nxt;
            sn      <= sn_nxt;
            wdog    <= wdog_nxt;
            done    <= done_nxt;
            timeout <= timeout_nxt;
            err     <= err_nxt;
        end
    end

    // next state and datapath: abort beats completion beats stepping beats watchdog
    always_comb begin
        state_nxt   = state;
        n_nxt       = n_reg;
        i_nxt       = i;
        sn_nxt      = sn;
        wdog_nxt    = wdog;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        err_nxt     = err | (state == RUN && sn != i);
        case (state)
            IDLE: if (start_valid) begin
                n_nxt     = n_in;
                i_nxt     = '0;
                sn_nxt    = '0;
                wdog_nxt  = '0;
                state_nxt = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (step_en) begin
                    if (i == n_reg) begin
                        state_nxt = FIN;
                        done_nxt  = 1'b1;
                    end else begin
                        i_nxt    = i + 1'b1;
                        sn_nxt   = sn + 1'b1;
                        wdog_nxt = '0;
                    end
                end else begin
                    wdog_nxt = wdog + 1'b1;
                    if (wdog == WD_LAST) begin
                        state_nxt   = IDLE;
                        timeout_nxt = 1'b1;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_loop_seq_ctrl.sv
// tb_loop_seq_ctrl: directed self-checking bench for loop_seq_ctrl
module tb_loop_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [7:0] n_in = '0;
    logic       step_en = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, timeout, err;
    logic [7:0] i, sn;
    int checks = 0;
    int failures = 0;

    loop_seq_ctrl #(.W(8), .TO_W(4), .TIMEOUT(12)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .n_in(n_in), .step_en(step_en), .abort(abort), .busy(busy), .i(i), .sn(sn),
        .done(done), .timeout(timeout), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] n);
        start_valid = 1'b1;
        n_in = n;
        tick;
        start_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_i;
        logic fin;
        int gap;
        @(negedge clk);
        chk("rst_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_i", i, 0);
        chk("rst_sn", sn, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        tick;

        // reset mid-run
        start_run(8'd10);
        step_en = 1'b1;
        repeat (4) tick;
        chk("mid_i", i, 4);
        chk("mid_busy", busy, 1);
        #1 rst = 1'b0;
        #1;
        chk("arst_i", i, 0);
        chk("arst_sn", sn, 0);
        chk("arst_ready", start_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("arst_hold_done", done, 0);

        // basic n=5
        start_run(8'd5);
        chk("b_busy", busy, 1);
        chk("b_i0", i, 0);
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk("b_i", i, k);
            chk("b_sn", sn, k);
            chk("b_nodone", done, 0);
        end
        tick;
        chk("b_done", done, 1);
        chk("b_fin_ready", start_ready, 0);
        chk("b_fin_busy", busy, 0);
        chk("b_fin_sn", sn, 5);
        tick;
        chk("b_done_off", done, 0);
        chk("b_ready", start_ready, 1);
        chk("b_err", err, 0);

        // zero bound
        start_run(8'd0);
        chk("z_busy", busy, 1);
        chk("z_nodone", done, 0);
        tick;
        chk("z_done", done, 1);
        chk("z_i", i, 0);
        chk("z_sn", sn, 0);
        tick;
        chk("z_done_off", done, 0);

        // max bound, random pacing with bounded gaps
        start_run(8'd255);
        exp_i = 8'd0;
        fin = 1'b0;
        gap = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            step_en = (gap >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            gap = step_en ? 0 : gap + 1;
            fin = step_en && exp_i == 8'd255;
            if (step_en && !fin) exp_i = exp_i + 8'd1;
            tick;
            chk("m_i", i, exp_i);
            chk("m_sn", sn, exp_i);
            chk("m_done", done, fin);
        end
        chk("m_done_end", done, 1);
        chk("m_sn_end", sn, 255);
        chk("m_err", err, 0);
        step_en = 1'b0;
        tick;

        // watchdog expiry
        start_run(8'd20);
        step_en = 1'b1;
        repeat (3) tick;
        chk("w_i", i, 3);
        step_en = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick;
            chk("w_busy", busy, 1);
            chk("w_nto", timeout, 0);
        end
        tick;
        chk("w_timeout", timeout, 1);
        chk("w_idle", start_ready, 1);
        chk("w_sn", sn, 3);
        chk("w_nodone", done, 0);
        tick;
        chk("w_to_off", timeout, 0);

        // abort on expiry cycle
        start_run(8'd20);
        step_en = 1'b1;
        repeat (3) tick;
        step_en = 1'b0;
        repeat (11) tick;
        chk("wa_busy", busy, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("wa_idle", busy, 0);
        chk("wa_nto", timeout, 0);
        chk("wa_sn", sn, 3);

        // protocol: start_valid held during RUN, abort at 7, restart n=2
        start_run(8'd20);
        step_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            start_valid = 1'b1;
            n_in = 8'(k);
            tick;
            chk("p_i", i, k);
            chk("p_busy", busy, 1);
            chk("p_nodone", done, 0);
        end
        start_valid = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("p_abort_busy", busy, 0);
        chk("p_abort_sn", sn, 7);
        chk("p_abort_done", done, 0);
        start_run(8'd2);
        chk("r_busy", busy, 1);
        chk("r_i0", i, 0);
        tick;
        tick;
        chk("r_i2", i, 2);
        tick;
        chk("r_done", done, 1);
        chk("r_sn", sn, 2);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("r_idle", start_ready, 1);
        chk("r_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/loop_seq_ctrl.md
Name: loop_seq_ctrl

Overview:
Controller that sequences the counting-loop datapath (loop index i, accumulator sn) for one bounded run per request. It accepts a bound n over a valid/ready handshake and advances the loop one iteration per enabled cycle under an external pacing input. It reports completion with the final sn and flags stalls via a watchdog. It sits between the bench/stimulus layer and the arithmetic loop core, replacing free-running iteration with start/done control.

Parameters:
W, 8, width of n, i, sn
TO_W, 4, width of watchdog counter
TIMEOUT, 12, consecutive stalled RUN cycles before abort (1..2^TO_W-1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
start_valid  input  1  request a run with bound n_in
start_ready  output  1  high in IDLE only
n_in  input  W  loop bound, sampled on start handshake
step_en  input  1  pacing; loop advances only in cycles where high (nondeterministic selector)
abort  input  1  synchronous cancel of active run
busy  output  1  high in RUN
i  output  W  iterations completed
sn  output  W  accumulator
done  output  1  one-cycle pulse on normal completion
timeout  output  1  one-cycle pulse on watchdog abort
err  output  1  sticky invariant violation, cleared only by reset

Behaviour:
- Reset (rst=0, async): state=IDLE; i=0, sn=0, n_reg=0, wdog=0; start_ready=1; busy=done=timeout=err=0. Reset mid-RUN discards the run immediately; no done/timeout pulse.
- States: IDLE, RUN, FIN.
- IDLE: start_ready=1. Handshake = start_valid & start_ready. On handshake: n_reg<=n_in, i<=0, sn<=0, wdog<=0, next=RUN. Without handshake, i/sn hold last run's values.
- RUN, priority order per cycle:
  1. abort=1 -> IDLE; i/sn hold; no pulses.
  2. step_en=1 and i==n_reg -> FIN; done=1 in that same cycle (registered, visible the following cycle); i/sn hold.
  3. step_en=1, i!=n_reg -> i<=i+1, sn<=sn+1, wdog<=0.
  4. step_en=0 -> wdog<=wdog+1. If wdog==TIMEOUT-1 -> IDLE with timeout pulse; i/sn hold.
- FIN: one cycle, start_ready=0; next=IDLE. done is registered, high exactly during the FIN cycle.
- Latency: n enabled steps of i/sn, plus one enabled exit step, then one FIN cycle. n=0 completes on the first enabled RUN cycle. Minimum start-to-done is 2 cycles. Back-to-back start is possible in the cycle after FIN.
- Arithmetic: i and sn are unsigned W-bit. Termination compares i==n_reg, never i<=n, so n=2^W-1 terminates with no wrap. i and sn never exceed n_reg.
- Invariant: in RUN, sn==i every cycle, and at done sn==n_reg. Any cycle with sn!=i sets err (checked combinationally, registered).
- start_valid outside IDLE is ignored; n_in is sampled only at handshake.
- abort in IDLE/FIN is ignored.
- abort and the watchdog expiry in the same cycle: abort wins, no timeout pulse.
- step_en at the final compare and the watchdog expiry cannot coincide, because a step clears wdog.

Test Plan:
- Reset mid-run: start n=10, step_en=1 for 4 cycles, pull rst low -> outputs immediately i=0, sn=0, start_ready=1, busy=0, no done.
- Basic: n_in=5, start_valid 1 cycle, step_en=1 continuously -> i/sn step 1..5, done pulse one cycle after i=5 reached, sn=5, start_ready returns the following cycle, err=0.
- Zero bound: n_in=0, step_en=1 -> done 2 cycles after handshake, sn=0, i=0.
- Max bound with random pacing: n_in=255, step_en random 50% with no 12-cycle gap -> done with sn=255, no wrap to 0, sn==i throughout, err=0.
- Watchdog: n_in=20, 3 steps then step_en=0 -> timeout pulse exactly 12 cycles into the stall, state IDLE, sn=3. Also abort asserted on the expiry cycle -> IDLE with no timeout pulse.
- Protocol: start_valid held high during RUN with changing n_in -> ignored. Abort at i=7 -> IDLE, sn=7, no done. Immediate restart n=2 -> completes with sn=2.
